// File: rtl/three_parallel_serializer.sv
// Output stage for the three-parallel FIR: requantizes each 64-bit lane to a
// signed OUT_W sample (round-half-up, saturate), buffers whole triples in a
// small FIFO and emits them serially in lane order 0,1,2 over valid/ready.
module three_parallel_serializer #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  din0,
    input  logic [IN_W-1:0]  din1,
    input  logic [IN_W-1:0]  din2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] dout,
    output logic [15:0]      sat_count
);

    localparam int AW = $clog2(DEPTH);

    // Rounding constant and clip limits, all at IN_W+1 bits so the biased
    // value cannot overflow.
    localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1) << (SHIFT-1);
    localparam logic signed [IN_W:0] MAXQ = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MINQ = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        PH0,
        PH1,
        PH2
    } phase_e;

    phase_e             phase_q, phase_d;
    logic [3*OUT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [OUT_W-1:0]   last_q, last_d;
    logic [15:0]        sat_q, sat_d;

    logic [3*OUT_W-1:0] head;
    logic [OUT_W-1:0]   head_lane;
    logic [OUT_W-1:0]   q0, q1, q2;
    logic               c0, c1, c2;
    logic [1:0]         n_clip;
    logic [16:0]        sat_sum;
    logic               push, pop, xfer, full, empty;

    // Returns {clipped, sample}: add half an LSB, arithmetic shift, then clip.
    function automatic logic [OUT_W:0] requant(input logic [IN_W-1:0] x);
        logic signed [IN_W:0] t;
        logic signed [IN_W:0] q;
        logic [OUT_W:0]       r;
        t = $signed({x[IN_W-1], x}) + RND;
        q = t >>> SHIFT;
        if (q > MAXQ) begin
            r = {1'b1, MAXQ[OUT_W-1:0]};
        end else if (q < MINQ) begin
            r = {1'b1, MINQ[OUT_W-1:0]};
        end else begin
            r = {1'b0, q[OUT_W-1:0]};
        end
        return r;
    endfunction

    assign {c0, q0} = requant(din0);
    assign {c1, q1} = requant(din1);
    assign {c2, q2} = requant(din2);

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = rst && !full;
    assign out_valid = rst && !empty;
    assign push      = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (phase_q == PH2);
    assign head      = mem_q[rd_ptr_q];

    // Select the lane of the head triple addressed by the current phase.
    always_comb begin
        head_lane = head[OUT_W-1:0];
        case (phase_q)
            PH1:     head_lane = head[2*OUT_W-1:OUT_W];
            PH2:     head_lane = head[3*OUT_W-1:2*OUT_W];
            default: head_lane = head[OUT_W-1:0];
        endcase
    end

    // dout keeps showing the last presented sample once the FIFO runs dry.
    assign dout      = !rst ? '0 : (empty ? last_q : head_lane);
    assign sat_count = sat_q;

    // Phase next-state: step through lanes on every output transfer.
    always_comb begin
        phase_d = phase_q;
        if (xfer) begin
            case (phase_q)
                PH0:     phase_d = PH1;
                PH1:     phase_d = PH2;
                default: phase_d = PH0;
            endcase
        end
    end

    // Phase state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= PH0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // FIFO pointers, occupancy, held output and saturation counter next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        n_clip   = {1'b0, c0} + {1'b0, c1} + {1'b0, c2};
        sat_sum  = {1'b0, sat_q} + 17'(n_clip);
        sat_d    = sat_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            sat_d    = sat_sum[16] ? '1 : sat_sum[15:0];
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (!empty) begin
            last_d = head_lane;
        end
    end

    // Control registers; reset drops every buffered triple.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            sat_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            sat_q    <= sat_d;
        end
    end

    // Triple storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {q2, q1, q0};
        end
    end

endmodule

// File: tb/tb_three_parallel_serializer.sv
// Self-checking bench for three_parallel_serializer: reset, directed table,
// backpressure, mid-triple reset, random traffic and sat_count saturation.
module tb_three_parallel_serializer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] din0 = '0;
    logic [63:0] din1 = '0;
    logic [63:0] din2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] dout;
    logic [15:0] sat_count;

    three_parallel_serializer #(
        .IN_W (64),
        .OUT_W(16),
        .SHIFT(15),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din0     (din0),
        .din1     (din1),
        .din2     (din2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: a queue of pending output samples in emission order.
    logic [15:0] mq[$];
    int          sat_m = 0;
    logic [15:0] last_m = '0;
    bit          seen_reset = 1'b0;

    logic        obs_ready, obs_valid;
    logic [15:0] obs_dout;

    typedef struct {
        logic signed [63:0] d0, d1, d2;
        logic [15:0]        e0, e1, e2;
        int                 sat;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Floor((x + 2^14) / 2^15) by integer division, then clip to 16 bits.
    function automatic logic [16:0] model_q(input logic signed [63:0] x);
        logic signed [127:0] t, f;
        t = 128'(x) + 128'sd16384;
        if (t >= 0) f = t / 128'sd32768;
        else        f = -((-t + 128'sd32767) / 128'sd32768);
        if (f > 32767)       return {1'b1, 16'h7FFF};
        else if (f < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, f[15:0]};
    endfunction

    task automatic model_push(input logic signed [63:0] x);
        logic [16:0] r;
        r = model_q(x);
        mq.push_back(r[15:0]);
        if (r[16]) sat_m++;
    endtask

    // One clock cycle: drive inputs, observe/check outputs, advance model.
    task automatic cyc(input bit r, input bit iv, input logic signed [63:0] a,
                       input logic signed [63:0] b, input logic signed [63:0] c,
                       input bit ordy, input bit chk);
        bit          exp_ready, exp_valid;
        logic [15:0] exp_dout;
        rst = r; in_valid = iv; din0 = a; din1 = b; din2 = c; out_ready = ordy;
        #1;
        obs_ready = in_ready;
        obs_valid = out_valid;
        obs_dout  = dout;
        exp_ready = r && (((mq.size() + 2) / 3) < DEPTH);
        exp_valid = r && (mq.size() > 0);
        exp_dout  = !r ? 16'h0 : (mq.size() > 0 ? mq[0] : last_m);
        if (chk) begin
            check("in_ready", 64'(obs_ready), 64'(exp_ready));
            check("out_valid", 64'(obs_valid), 64'(exp_valid));
            check("dout", 64'(obs_dout), 64'(exp_dout));
            if (seen_reset) check("sat_count", 64'(sat_count), 64'(sat_m));
        end
        if (!r) begin
            mq.delete();
            sat_m = 0;
            last_m = '0;
            seen_reset = 1'b1;
        end else begin
            if (mq.size() > 0) last_m = mq[0];
            if (ordy && mq.size() > 0) void'(mq.pop_front());
            if (iv && exp_ready) begin
                model_push(a);
                model_push(b);
                model_push(c);
                if (sat_m > 65535) sat_m = 65535;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 1, 1);
    endtask

    function automatic logic signed [63:0] rnd_val();
        logic signed [31:0] s;
        int k;
        case ($urandom_range(3))
            0: return {$urandom, $urandom};
            1: begin s = $urandom; return 64'(s); end
            2: begin k = int'($urandom_range(0, 1 << 23)) - (1 << 22); return 64'(k); end
            default: begin
                k = int'($urandom_range(0, 200)) - 100;
                return 64'(k * 32768 + 16384 + int'($urandom_range(0, 2)) - 1);
            end
        endcase
    endfunction

    initial begin
        logic [15:0] rec[$];
        int acc;
        int budget;
        logic signed [63:0] big, neg;
        big = 64'sd1125899906842624;          // 2^50
        neg = 64'sh8000_0000_0000_0000;       // -2^63

        tbl[0] = '{d0: 64'sd32768, d1: 64'sd65536, d2: -64'sd98304,
                   e0: 16'd1, e1: 16'd2, e2: 16'hFFFD, sat: 0};
        tbl[1] = '{d0: 64'sd16384, d1: 64'sd16383, d2: -64'sd16385,
                   e0: 16'd1, e1: 16'd0, e2: 16'hFFFF, sat: 0};
        tbl[2] = '{d0: -64'sd16384, d1: 64'sd1073709056, d2: 64'sd0,
                   e0: 16'd0, e1: 16'd32767, e2: 16'd0, sat: 0};
        tbl[3] = '{d0: big, d1: neg, d2: 64'sd1073741824,
                   e0: 16'h7FFF, e1: 16'h8000, e2: 16'h7FFF, sat: 3};

        // Reset held with in_valid asserted.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 64'sd32768, 64'sd32768, 64'sd32768, 0, 1);
            check("rst_in_ready", 64'(obs_ready), 64'd0);
            check("rst_out_valid", 64'(obs_valid), 64'd0);
            check("rst_dout", 64'(obs_dout), 64'd0);
        end
        check("rst_sat_count", 64'(sat_count), 64'd0);
        cyc(1, 0, 0, 0, 0, 1, 1);
        check("post_rst_in_ready", 64'(obs_ready), 64'd1);

        // Directed vectors: lane order, rounding, saturation.
        foreach (tbl[v]) begin
            cyc(1, 1, tbl[v].d0, tbl[v].d1, tbl[v].d2, 1, 1);
            cyc(1, 0, 0, 0, 0, 1, 1);
            check($sformatf("tbl%0d_lane0", v), 64'(obs_dout), 64'(tbl[v].e0));
            check($sformatf("tbl%0d_v0", v), 64'(obs_valid), 64'd1);
            cyc(1, 0, 0, 0, 0, 1, 1);
            check($sformatf("tbl%0d_lane1", v), 64'(obs_dout), 64'(tbl[v].e1));
            cyc(1, 0, 0, 0, 0, 1, 1);
            check($sformatf("tbl%0d_lane2", v), 64'(obs_dout), 64'(tbl[v].e2));
            cyc(1, 0, 0, 0, 0, 1, 1);
            check($sformatf("tbl%0d_empty", v), 64'(obs_valid), 64'd0);
            check($sformatf("tbl%0d_sat", v), 64'(sat_count), 64'(tbl[v].sat));
        end

        // Backpressure: two triples fill the FIFO, third waits for a pop.
        cyc(1, 1, 64'sd32768, 64'sd65536, 64'sd98304, 0, 1);
        cyc(1, 1, 64'sd131072, 64'sd163840, 64'sd196608, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 64'sd229376, 64'sd262144, 64'sd294912, 0, 1);
            check("bp_full_ready", 64'(obs_ready), 64'd0);
        end
        acc = -1;
        for (int i = 0; i < 12 && acc < 0; i++) begin
            cyc(1, 1, 64'sd229376, 64'sd262144, 64'sd294912, 1, 1);
            if (obs_valid) rec.push_back(obs_dout);
            if (obs_ready) acc = i;
        end
        check("bp_accept_cycle", 64'(acc), 64'd3);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 0, 0, 1, 1);
            if (obs_valid) rec.push_back(obs_dout);
        end
        check("bp_count", 64'(rec.size()), 64'd9);
        for (int i = 0; i < rec.size() && i < 9; i++)
            check($sformatf("bp_seq%0d", i), 64'(rec[i]), 64'(i + 1));

        // Reset after the first sample of a triple has transferred.
        cyc(1, 1, 64'sd360448, 64'sd393216, 64'sd425984, 1, 1);
        cyc(1, 0, 0, 0, 0, 1, 1);
        check("mid_first", 64'(obs_dout), 64'd11);
        cyc(0, 0, 0, 0, 0, 1, 1);
        check("mid_rst_valid", 64'(obs_valid), 64'd0);
        cyc(1, 1, 64'sd688128, 64'sd720896, 64'sd753664, 1, 1);
        check("mid_after_valid", 64'(obs_valid), 64'd0);
        cyc(1, 0, 0, 0, 0, 1, 1);
        check("mid_restart_lane0", 64'(obs_dout), 64'd21);
        check("mid_restart_valid", 64'(obs_valid), 64'd1);
        idle(4);

        // Random traffic against the queue model.
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(99) != 0), $urandom_range(1), rnd_val(), rnd_val(), rnd_val(),
                $urandom_range(3) != 0, 1);
        end

        // sat_count saturation: climb to 65534, then push past 65535.
        cyc(0, 0, 0, 0, 0, 1, 1);
        budget = 80000;
        while (sat_m < 65532 && budget > 0) begin
            cyc(1, 1, big, neg, big, 1, 0);
            budget--;
        end
        while (sat_m < 65534 && budget > 0) begin
            cyc(1, 1, big, -big, 64'sd0, 1, 0);
            budget--;
        end
        check("sat_budget_left", 64'(budget > 0), 64'd1);
        idle(8);
        check("sat_65534", 64'(sat_count), 64'd65534);
        for (int k = 0; k < 2; k++) begin
            acc = 0;
            for (int i = 0; i < 10 && acc == 0; i++) begin
                cyc(1, 1, big, neg, big, 1, 1);
                acc = obs_ready ? 1 : 0;
            end
            check("sat_push_taken", 64'(acc), 64'd1);
            idle(8);
            check("sat_65535", 64'(sat_count), 64'd65535);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
